// File: rtl/ritc_train_scheduler.sv
// Round-robin RITC link-training sequencer sharing one alignment engine between two RITCs.
// Optional build macro RITC_TRAIN_RETRY_EN: failed alignments retry up to 3 times before reporting.
module ritc_train_scheduler #(
  parameter int SETTLE_CYCLES = 1024,
  parameter int ALIGN_TIMEOUT = 65535
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sync_i,
  input  logic [1:0] train_req_i,
  output logic       align_req_o,
  output logic       align_sel_o,
  input  logic       align_ack_i,
  input  logic       align_ok_i,
  output logic [1:0] TRAIN,
  output logic [1:0] VCDL,
  output logic       busy_o,
  output logic [1:0] train_done_o,
  output logic [1:0] train_ok_o
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = (ALIGN_TIMEOUT > 1) ? $clog2(ALIGN_TIMEOUT) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(ALIGN_TIMEOUT - 1);

  // IDLE arbitrate | SETTLE hold TRAIN | ALIGN engine owned | WAIT_SYNC | FIRE VCDL | DONE report
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_ALIGN, S_WAIT_SYNC, S_FIRE, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_sel, w_sel_nxt;
  logic            r_last, w_last_nxt;
  logic [1:0]      r_pend;
  logic [1:0]      w_grant;
  logic [SW-1:0]   r_settle, w_settle_nxt;
  logic [TW-1:0]   r_to, w_to_nxt;
  logic            r_res, w_res_nxt;
  logic [1:0]      w_onehot;
  logic [1:0]      w_ok_nxt;
  logic [1:0]      r_train, r_vcdl, r_done, r_ok;
  logic            r_align_req, r_busy;
`ifdef RITC_TRAIN_RETRY_EN
  logic [1:0]      r_retry, w_retry_nxt;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_last_nxt   = r_last;
    w_settle_nxt = r_settle;
    w_to_nxt     = r_to;
    w_res_nxt    = r_res;
    w_grant      = 2'b00;
`ifdef RITC_TRAIN_RETRY_EN
    w_retry_nxt  = r_retry;
`endif
    case (r_state)
      S_IDLE: if (r_pend != 2'b00) begin
        w_sel_nxt    = (r_pend == 2'b11) ? ~r_last : r_pend[1];
        w_last_nxt   = w_sel_nxt;
        w_grant      = w_sel_nxt ? 2'b10 : 2'b01;
        w_settle_nxt = SETTLE_LOAD;
        w_res_nxt    = 1'b0;
        w_state_nxt  = S_SETTLE;
`ifdef RITC_TRAIN_RETRY_EN
        w_retry_nxt  = 2'd0;
`endif
      end
      S_SETTLE: begin
        if (r_settle == '0) begin
          w_to_nxt    = '0;
          w_state_nxt = S_ALIGN;
        end else begin
          w_settle_nxt = r_settle - SW'(1);
        end
      end
      S_ALIGN: begin
        // an ack landing on the timeout cycle still counts as a real result
        if (align_ack_i && align_ok_i) begin
          w_res_nxt   = 1'b1;
          w_state_nxt = S_WAIT_SYNC;
        end else if (align_ack_i || (r_to == TO_LAST)) begin
`ifdef RITC_TRAIN_RETRY_EN
          if (r_retry != 2'd3) begin
            w_retry_nxt  = r_retry + 2'd1;
            w_settle_nxt = SETTLE_LOAD;
            w_state_nxt  = S_SETTLE;
          end else begin
            w_res_nxt   = 1'b0;
            w_state_nxt = S_WAIT_SYNC;
          end
`else
          w_res_nxt   = 1'b0;
          w_state_nxt = S_WAIT_SYNC;
`endif
        end else begin
          w_to_nxt = r_to + TW'(1);
        end
      end
      S_WAIT_SYNC: if (sync_i) w_state_nxt = r_res ? S_FIRE : S_DONE;
      S_FIRE:      w_state_nxt = S_DONE;
      S_DONE:      w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
    w_onehot = w_sel_nxt ? 2'b10 : 2'b01;
    w_ok_nxt = r_ok;
    if (w_state_nxt == S_DONE) w_ok_nxt[w_sel_nxt] = w_res_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_sel       <= 1'b0;
      r_last      <= 1'b1;
      r_pend      <= 2'b00;
      r_settle    <= '0;
      r_to        <= '0;
      r_res       <= 1'b0;
      r_train     <= 2'b00;
      r_vcdl      <= 2'b00;
      r_align_req <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 2'b00;
      r_ok        <= 2'b00;
`ifdef RITC_TRAIN_RETRY_EN
      r_retry     <= 2'd0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_last      <= w_last_nxt;
      r_pend      <= (r_pend & ~w_grant) | train_req_i;
      r_settle    <= w_settle_nxt;
      r_to        <= w_to_nxt;
      r_res       <= w_res_nxt;
      r_train     <= ((w_state_nxt == S_SETTLE) || (w_state_nxt == S_ALIGN)) ? w_onehot : 2'b00;
      r_vcdl      <= (w_state_nxt == S_FIRE) ? w_onehot : 2'b00;
      r_align_req <= (w_state_nxt == S_ALIGN);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE) ? w_onehot : 2'b00;
      r_ok        <= w_ok_nxt;
`ifdef RITC_TRAIN_RETRY_EN
      r_retry     <= w_retry_nxt;
`endif
    end
  end

  assign align_req_o  = r_align_req;
  assign align_sel_o  = r_sel;
  assign TRAIN        = r_train;
  assign VCDL         = r_vcdl;
  assign busy_o       = r_busy;
  assign train_done_o = r_done;
  assign train_ok_o   = r_ok;

endmodule

// File: tb/tb_ritc_train_scheduler.sv
// Bench for ritc_train_scheduler: vector table, hand-written corner sequences and randomized services.
module tb_ritc_train_scheduler;

  localparam int SETTLE = 16;
  localparam int TO     = 64;

  logic       clk_i;
  logic       rst_i;
  logic       sync_i;
  logic [1:0] train_req_i;
  logic       align_req_o;
  logic       align_sel_o;
  logic       align_ack_i;
  logic       align_ok_i;
  logic [1:0] TRAIN;
  logic [1:0] VCDL;
  logic       busy_o;
  logic [1:0] train_done_o;
  logic [1:0] train_ok_o;

  ritc_train_scheduler #(.SETTLE_CYCLES(SETTLE), .ALIGN_TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sync_i(sync_i), .train_req_i(train_req_i),
    .align_req_o(align_req_o), .align_sel_o(align_sel_o), .align_ack_i(align_ack_i),
    .align_ok_i(align_ok_i), .TRAIN(TRAIN), .VCDL(VCDL), .busy_o(busy_o),
    .train_done_o(train_done_o), .train_ok_o(train_ok_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference state: pending requests, last grant, last result per RITC
  logic [1:0] m_pend;
  logic       m_last;
  logic [1:0] m_ok;

  typedef struct {
    logic [1:0] req;
    int         dly;
    logic       ok;
    logic [1:0] mid;
    logic       sel;
    logic       sel2;
    logic       pass;
  } vec_t;
  vec_t tbl[8];

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    sync_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #2 sync_i = ~sync_i;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "bench stalled");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_train"}, TRAIN, 0);
    chk({tag, "_vcdl"}, VCDL, 0);
    chk({tag, "_align_req"}, align_req_o, 0);
    chk({tag, "_align_sel"}, align_sel_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, train_done_o, 0);
    chk({tag, "_ok"}, train_ok_o, 0);
  endtask

  function automatic logic pick(input logic [1:0] p, input logic last);
    return (p == 2'b11) ? ~last : p[1];
  endfunction

  // One complete training of RITC es, called at a negedge with the DUT idle or about to grant.
  task automatic run_service(input logic [1:0] req, input logic [1:0] mid, input logic es,
                             input int dly, input logic ok, input logic exp_pass, input bit abort);
    int waited, cnt, held, k, first_sync, vc_k, done_k, vcnt, attempts;
    logic [1:0] oh;
    oh = es ? 2'b10 : 2'b01;
`ifdef RITC_TRAIN_RETRY_EN
    attempts = exp_pass ? 1 : 4;
`else
    attempts = 1;
`endif
    train_req_i = req;
    waited = 0;
    while (TRAIN == 2'b00 && waited < 50) begin
      @(negedge clk_i);
      train_req_i = 2'b00;
      waited++;
    end
    train_req_i = 2'b00;
    chk("train_latency", waited, (req == 2'b00) ? 1 : 2);
    chk("train_sel", TRAIN, oh);
    chk("align_sel", align_sel_o, es);
    chk("busy_on", busy_o, 1);
    m_last = es;
    for (int a = 0; a < attempts; a++) begin
      cnt = 0;
      while (!align_req_o && cnt < 100) begin
        if (a == 0 && cnt == 5) train_req_i = mid;
        @(negedge clk_i);
        train_req_i = 2'b00;
        cnt++;
      end
      chk("settle_len", cnt, SETTLE);
      chk("train_in_align", TRAIN, oh);
      held = 0;
      while (align_req_o && held < 200) begin
        if (abort && held == dly) begin
          rst_i = 1'b1;
          @(negedge clk_i);
          rst_i = 1'b0;
          m_pend = 2'b00;
          m_last = 1'b1;
          m_ok   = 2'b00;
          chk_reset("abort");
          return;
        end
        if (held == dly) begin
          align_ack_i = 1'b1;
          align_ok_i  = ok;
        end
        @(negedge clk_i);
        align_ack_i = 1'b0;
        align_ok_i  = 1'b0;
        held++;
      end
      chk("align_len", held, (dly < TO) ? dly + 1 : TO);
      if (a < attempts - 1) chk("train_retry", TRAIN, oh);
      else chk("train_off", TRAIN, 0);
    end
    k = 0; first_sync = -1; vc_k = -1; done_k = -1; vcnt = 0;
    while (done_k < 0 && k < 20) begin
      if (first_sync < 0 && sync_i) first_sync = k;
      if (VCDL != 2'b00) begin
        vcnt++;
        vc_k = k;
        chk("vcdl_sel", VCDL, oh);
        chk("vcdl_phase", sync_i, 0);
      end
      if (train_done_o != 2'b00) done_k = k;
      else begin
        @(negedge clk_i);
        k++;
      end
    end
    chk("vcdl_count", vcnt, exp_pass ? 1 : 0);
    if (exp_pass) chk("vcdl_cycle", vc_k, first_sync + 1);
    chk("done_cycle", done_k, first_sync + 1 + (exp_pass ? 1 : 0));
    chk("done_sel", train_done_o, oh);
    chk("busy_done", busy_o, 1);
    m_ok[es] = exp_pass;
    chk("train_ok", train_ok_o, m_ok);
    @(negedge clk_i);
    chk("done_width", train_done_o, 0);
    chk("ok_hold", train_ok_o, m_ok);
  endtask

  initial begin
    logic [1:0] m, mid;
    logic       ok, s, first;
    int         dly;

    tbl[0] = '{2'b01,  7, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{2'b10,  0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{2'b01, 10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{2'b10, 99, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{2'b01, 63, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{2'b10, 63, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{2'b01,  3, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{2'b10,  2, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1};

    rst_i = 1'b1; train_req_i = 2'b00; align_ack_i = 1'b0; align_ok_i = 1'b0;
    m_pend = 2'b00; m_last = 1'b1; m_ok = 2'b00;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_reset("reset");

    // both at once from reset: RITC 0 first, RITC 1 straight after
    run_service(2'b11, 2'b00, 1'b0, 4, 1'b1, 1'b1, 1'b0);
    run_service(2'b00, 2'b00, 1'b1, 4, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_service(tbl[i].req, tbl[i].mid, tbl[i].sel, tbl[i].dly, tbl[i].ok, tbl[i].pass, 1'b0);
      if (tbl[i].mid != 2'b00)
        run_service(2'b00, 2'b00, tbl[i].sel2, tbl[i].dly, tbl[i].ok, tbl[i].pass, 1'b0);
    end

    // stray ack while idle must not start anything
    align_ack_i = 1'b1; align_ok_i = 1'b1;
    @(negedge clk_i);
    align_ack_i = 1'b0; align_ok_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("stray_ack_busy", busy_o, 0);
    chk("stray_ack_done", train_done_o, 0);
    chk("stray_ack_ok", train_ok_o, m_ok);

    // reset during RITC 1 ALIGN with RITC 0 pending
    run_service(2'b10, 2'b01, 1'b1, 20, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      chk("post_abort_busy", busy_o, 0);
      chk("post_abort_done", train_done_o, 0);
    end
    run_service(2'b01, 2'b00, 1'b0, 5, 1'b1, 1'b1, 1'b0);

    for (int it = 0; it < 30; it++) begin
      m   = 2'($urandom_range(3, 1));
      mid = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 0)) : 2'b00;
      dly = $urandom_range(70, 0);
      ok  = 1'($urandom_range(1, 0));
      m_pend = m_pend | m;
      first = 1'b1;
      while (m_pend != 2'b00) begin
        s = pick(m_pend, m_last);
        m_pend[s] = 1'b0;
        if (first) m_pend = m_pend | mid;
        run_service(first ? m : 2'b00, first ? mid : 2'b00, s, dly, ok,
                    (dly < TO) && ok, 1'b0);
        first = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
